// File: rtl/lag_meter.sv
// Display input-lag meter: frame_start to debounced photo-sensor edge, in us.
// Optional LAG_METER_AVG_EN adds an 8-result moving average output (avg_us).
module lag_meter #(
    parameter int   TICKS_PER_US = 74,
    parameter int   CNT_W        = 20,
    parameter int   DEBOUNCE     = 8,
    parameter logic SENSOR_ACT   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             sensor,
    output logic             sensor_level,
    output logic             busy,
    output logic [CNT_W-1:0] lag_us,
    output logic             lag_valid,
`ifdef LAG_METER_AVG_EN
    output logic             lag_timeout,
    output logic [CNT_W-1:0] avg_us
`else
    output logic             lag_timeout
`endif
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic          sync_a;
    logic          sync_b;
    logic          sample;
    logic [DW-1:0] deb_cnt;

    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] us_cnt;
    logic [CNT_W-1:0] us_next;
    logic             pre_wrap;
    logic             us_max;

    logic start;
    logic hit;
    logic sat;

    // Two-flop synchroniser; resets to the dark level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= ~SENSOR_ACT;
            sync_b <= ~SENSOR_ACT;
        end else begin
            sync_a <= sensor;
            sync_b <= sync_a;
        end
    end

    assign sample = (sync_b == SENSOR_ACT);

    // Debounce: flip the level after DEBOUNCE consecutive differing samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_cnt      <= '0;
            sensor_level <= 1'b0;
        end else if (sample != sensor_level) begin
            if (deb_cnt == DW'(DEBOUNCE - 1)) begin
                sensor_level <= sample;
                deb_cnt      <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign pre_wrap = (pre == PW'(TICKS_PER_US - 1));
    assign us_max   = (us_cnt == '1);
    assign us_next  = (pre_wrap && !us_max) ? us_cnt + 1'b1 : us_cnt;

    // Timebase: prescaler and saturating us counter, running only while measuring
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (start) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (state == MEASURE) begin
            pre    <= pre_wrap ? '0 : pre + 1'b1;
            us_cnt <= us_next;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and measurement events; enable low overrides everything
    always_comb begin
        state_next = state;
        start      = 1'b0;
        hit        = 1'b0;
        sat        = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = ARMED;
                end
                ARMED: begin
                    if (frame_start && !sensor_level) begin
                        state_next = MEASURE;
                        start      = 1'b1;
                    end
                end
                MEASURE: begin
                    if (sensor_level) begin
                        hit        = 1'b1;
                        state_next = HOLD;
                    end else if (us_max) begin
                        sat        = 1'b1;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (!sensor_level) begin
                        state_next = ARMED;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == MEASURE);

    // Result register; the detection cycle itself is counted in the lag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lag_us      <= '0;
            lag_valid   <= 1'b0;
            lag_timeout <= 1'b0;
        end else begin
            lag_valid   <= hit;
            lag_timeout <= sat;
            if (hit) begin
                lag_us <= us_next;
            end else if (sat) begin
                lag_us <= '1;
            end
        end
    end

`ifdef LAG_METER_AVG_EN
    logic [CNT_W-1:0] ring [8];
    logic [2:0]       ptr;
    logic [CNT_W+2:0] sum;

    // Ring of the last eight good results with a running sum
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                ring[i] <= '0;
            end
            ptr <= '0;
            sum <= '0;
        end else if (lag_valid) begin
            ring[ptr] <= lag_us;
            ptr       <= ptr + 1'b1;
            sum       <= sum - {3'b000, ring[ptr]} + {3'b000, lag_us};
        end
    end

    assign avg_us = sum[CNT_W+2:3];
`endif

endmodule

// File: tb/tb_lag_meter.sv
// Bench for lag_meter at TICKS_PER_US=4, DEBOUNCE=2, CNT_W=8.
// Expected results are queued on stimulus and matched against observed pulses.
module tb_lag_meter;

    localparam int TPU = 4;
    localparam int CW  = 8;
    localparam int DB  = 2;

    logic          clock       = 1'b0;
    logic          reset       = 1'b0;
    logic          enable      = 1'b0;
    logic          frame_start = 1'b0;
    logic          sensor      = 1'b0;
    logic          sensor_level;
    logic          busy;
    logic [CW-1:0] lag_us;
    logic          lag_valid;
    logic          lag_timeout;
`ifdef LAG_METER_AVG_EN
    logic [CW-1:0] avg_us;
`endif

    int checks = 0;
    int errors = 0;

    logic [CW+1:0] exp_q [$];
    logic [CW+1:0] obs_q [$];

    always #5 clock = ~clock;

    lag_meter #(
        .TICKS_PER_US(TPU),
        .CNT_W       (CW),
        .DEBOUNCE    (DB),
        .SENSOR_ACT  (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .sensor      (sensor),
        .sensor_level(sensor_level),
        .busy        (busy),
        .lag_us      (lag_us),
        .lag_valid   (lag_valid),
`ifdef LAG_METER_AVG_EN
        .lag_timeout (lag_timeout),
        .avg_us      (avg_us)
`else
        .lag_timeout (lag_timeout)
`endif
    );

    // Record every result pulse as {timeout, valid, lag}
    always @(negedge clock) begin
        if (lag_valid || lag_timeout)
            obs_q.push_back({lag_timeout, lag_valid, lag_us});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Frame pulse, then sensor high d cycles after the pulse cycle
    task automatic measure(input int d, input logic [CW-1:0] lag);
        exp_q.push_back({2'b01, lag});
        pulse_frame();
        tick(d - 1);
        sensor = 1'b1;
    endtask

    task automatic wait_obs(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (obs_q.size() != 0) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        if (obs_q.size() != 0) got = 1'b1;
    endtask

    task automatic settle();
        sensor = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        logic [CW+3:0] outs;
        tick(2);
        outs = {sensor_level, busy, lag_us, lag_valid, lag_timeout};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        reset = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle busy %b pulses %0d want 0 0",
                     busy, obs_q.size());
        end
    endtask

    task automatic test_measure();
        bit            got;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        enable = 1'b1;
        tick(2);
        measure(400, 8'd101);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL meas_busy got %b want 1", busy);
        end
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL meas_result none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL meas_result got %h want %h", o, e);
            end
        end
        tick(3);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL meas_after busy %b extra %0d want 0 0",
                     busy, obs_q.size());
        end
        pulse_frame();
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignore busy %b want 0", busy);
        end
        settle();
    endtask

    task automatic test_timeout();
        bit            got;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        exp_q.push_back({2'b10, 8'hFF});
        pulse_frame();
        wait_obs(1200, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_result none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_result got %h want %h", o, e);
            end
        end
        tick(3);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0 || lag_us !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_after busy %b extra %0d lag %h want 0 0 ff",
                     busy, obs_q.size(), lag_us);
        end
        measure(16, 8'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_busy got %b want 1", busy);
        end
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rearm_result none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL rearm_result got %h want %h", o, e);
            end
        end
        settle();
    endtask

    task automatic test_sensor_high();
        bit            got;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        sensor = 1'b1;
        tick(8);
        pulse_frame();
        tick(5);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL lit_ignore busy %b pulses %0d want 0 0",
                     busy, obs_q.size());
        end
        sensor = 1'b0;
        tick(8);
        measure(24, 8'd7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dark_start busy %b want 1", busy);
        end
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL dark_result none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL dark_result got %h want %h", o, e);
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        bit            got;
        bit            seen;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        exp_q.push_back({2'b01, 8'd6});
        pulse_frame();
        tick(9);
        sensor = 1'b1;
        tick(1);
        sensor = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            seen |= sensor_level;
            tick(1);
        end
        checks++;
        if (seen || obs_q.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch level %b pulses %0d busy %b want 0 0 1",
                     seen, obs_q.size(), busy);
        end
        sensor = 1'b1;
        tick(3);
        sensor = 1'b0;
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL pulse3_result none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL pulse3_result got %h want %h", o, e);
            end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        bit            got;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        measure(8, 8'd3);
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_first none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_first got %h want %h", o, e);
            end
        end
        sensor = 1'b0;
        tick(6);
        measure(32, 8'd9);
        wait_obs(50, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_second none want %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_second got %h want %h", o, e);
            end
        end
        settle();
    endtask

    task automatic test_enable();
        pulse_frame();
        tick(10);
        enable = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL en_abort busy %b want 0", busy);
        end
        sensor = 1'b1;
        tick(12);
        checks++;
        if (obs_q.size() != 0 || lag_us !== 8'd9) begin
            errors++;
            $display("FAIL en_keep pulses %0d lag %0d want 0 9",
                     obs_q.size(), lag_us);
        end
        sensor = 1'b0;
        enable = 1'b1;
        tick(10);
    endtask

    task automatic test_reset_mid();
        logic [CW+3:0] outs;
        pulse_frame();
        tick(20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre busy %b want 1", busy);
        end
        reset = 1'b0;
        #1;
        outs = {sensor_level, busy, lag_us, lag_valid, lag_timeout};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_async got %h want 0", outs);
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        sensor = 1'b1;
        tick(15);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0 || lag_us !== '0) begin
            errors++;
            $display("FAIL rst_after pulses %0d busy %b lag %0d want 0 0 0",
                     obs_q.size(), busy, lag_us);
        end
        settle();
    endtask

`ifdef LAG_METER_AVG_EN
    task automatic test_avg();
        bit            got;
        logic [CW+1:0] o;
        logic [CW+1:0] e;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        for (int k = 1; k <= 9; k++) begin
            measure(40 * k - 4, 8'(10 * k));
            wait_obs(60, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL avg_result%0d none want %h", k, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL avg_result%0d got %h want %h", k, o, e);
                end
            end
            tick(1);
            if (k == 8) begin
                checks++;
                if (avg_us !== 8'd45) begin
                    errors++;
                    $display("FAIL avg_eight got %0d want 45", avg_us);
                end
            end
            if (k == 9) begin
                checks++;
                if (avg_us !== 8'd55) begin
                    errors++;
                    $display("FAIL avg_nine got %0d want 55", avg_us);
                end
            end
            settle();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_measure();
        test_timeout();
        test_sensor_high();
        test_glitch();
        test_back_to_back();
        test_enable();
        test_reset_mid();
`ifdef LAG_METER_AVG_EN
        test_avg();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog run did not finish");
        $fatal(1);
    end

endmodule
